// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and constants for the pipeline hazard/halt control
package pipe_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DEF_DRAIN_CYCLES = 3;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       lu
);
  assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and end-of-program drain/halt sequencing
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_fin,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  state_t        st, st_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic          lu, stall_inc, flush_inc, flush_all, freeze;
  load_use_detect u_lu (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rt      (ex_rt),
    .lu         (lu)
  );
  // Mealy next-state and control; reset forces no-event outputs, illegal encoding acts as HALT
  always_comb begin
    st_nx     = st;
    dcnt_nx   = dcnt;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    flush_all = 1'b0;
    freeze    = 1'b0;
    halted    = 1'b0;
    if (!rst_n) begin
      st_nx = RUN;
    end else if (st == RUN) begin
      if (mem_branch_taken) begin
        flush_all = 1'b1;
        flush_inc = 1'b1;
      end else if (ex_fin) begin
        freeze    = 1'b1;
        stall_inc = lu;
        st_nx     = DRAIN;
        dcnt_nx   = DW'(DRAIN_CYCLES - 1);
      end else if (lu) begin
        freeze    = 1'b1;
        stall_inc = 1'b1;
      end
    end else if (st == DRAIN) begin
      if (mem_branch_taken) begin
        flush_all = 1'b1;
        flush_inc = 1'b1;
        st_nx     = RUN;
      end else begin
        freeze  = 1'b1;
        st_nx   = (dcnt == '0) ? HALT : DRAIN;
        dcnt_nx = (dcnt == '0) ? dcnt : dcnt - DW'(1);
      end
    end else begin
      freeze = 1'b1;
      halted = 1'b1;
      st_nx  = HALT;
    end
  end
  assign pc_write     = !freeze;
  assign if_id_write  = !freeze;
  assign id_ex_bubble = freeze;
  assign if_id_flush  = flush_all;
  assign id_ex_flush  = flush_all;
  assign ex_mem_flush = flush_all;
  // State, drain countdown and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RUN;
      dcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      st   <= st_nx;
      dcnt <= dcnt_nx;
      if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, flush, drain/halt, reset and saturation
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, ex_fin, mem_branch_taken;
  logic        pc_write, if_id_write, id_ex_bubble;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;
  int          n_pass = 0;
  int          n_total = 0;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_fin          (ex_fin),
    .mem_branch_taken(mem_branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_fin = 1'b0; mem_branch_taken = 1'b0;
  endtask

  task automatic chk_ctrl(input string tag, input logic [5:0] exp);
    chk(tag, {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush}, {26'd0, exp});
  endtask

  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b001000;
  localparam logic [5:0] C_FLUSH = 6'b110111;

  initial begin
    idle();
    rst_n = 1'b0;
    mem_branch_taken = 1'b1;
    ex_fin = 1'b1;
    #2;
    chk_ctrl("reset_ctrl", C_RUN);
    chk("reset_halted", halted, 0);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_flush", flush_cnt, 0);
    idle();
    #11 rst_n = 1'b1;
    step();
    // ex_rt = 0 never stalls
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1 chk_ctrl("zero_reg_ctrl", C_RUN);
    step();
    chk("zero_reg_cnt", stall_cnt, 0);
    // load-use through rs
    ex_rt = 5'd8; id_rs = 5'd8;
    #1 chk_ctrl("lu_rs_ctrl", C_STALL);
    step();
    idle();
    #1 chk("lu_rs_cnt", stall_cnt, 1);
    chk_ctrl("lu_rs_after", C_RUN);
    // rt-only match depends on id_uses_rt
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1 chk_ctrl("rt_unused_ctrl", C_RUN);
    step();
    chk("rt_unused_cnt", stall_cnt, 1);
    id_uses_rt = 1'b1;
    #1 chk_ctrl("rt_used_ctrl", C_STALL);
    step();
    chk("rt_used_cnt", stall_cnt, 2);
    // branch beats load-use
    mem_branch_taken = 1'b1;
    #1 chk_ctrl("br_lu_ctrl", C_FLUSH);
    step();
    idle();
    #1 chk("br_lu_flush", flush_cnt, 1);
    chk("br_lu_stall", stall_cnt, 2);
    // wrong-path fin
    ex_fin = 1'b1; mem_branch_taken = 1'b1;
    #1 chk_ctrl("wp_fin_ctrl", C_FLUSH);
    step();
    idle();
    #1 chk("wp_fin_halted", halted, 0);
    chk_ctrl("wp_fin_run", C_RUN);
    chk("wp_fin_flush", flush_cnt, 2);
    // fin with overlapping load-use: stall counted, then drain ignores lu
    ex_fin = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    #1 chk_ctrl("fin_ctrl", C_STALL);
    step();
    ex_fin = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      chk($sformatf("drain%0d_halted", d), halted, 0);
      chk_ctrl($sformatf("drain%0d_ctrl", d), C_STALL);
      step();
    end
    chk("halt_entry", halted, 1);
    chk("drain_stall_cnt", stall_cnt, 3);
    for (int h = 0; h < 10; h++) begin
      mem_branch_taken = h[0];
      ex_fin = h[1];
      #1 chk($sformatf("halt%0d", h), {halted, pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush}, 7'b1001000);
      step();
    end
    chk("halt_flush_cnt", flush_cnt, 2);
    chk("halt_stall_cnt", stall_cnt, 3);
    // asynchronous reset from HALT
    idle();
    #2 rst_n = 1'b0;
    #1 chk("areset_halted", halted, 0);
    chk_ctrl("areset_ctrl", C_RUN);
    chk("areset_stall", stall_cnt, 0);
    chk("areset_flush", flush_cnt, 0);
    #1 rst_n = 1'b1;
    step();
    chk("post_reset_halted", halted, 0);
    // stall counter saturation
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    for (int i = 0; i < 70000; i++) step();
    chk("sat_stall", stall_cnt, 16'hFFFF);
    chk_ctrl("sat_ctrl", C_STALL);
    step();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
